// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text sequencer.
// LCD_AUTO_REFRESH_EN (top-level macro) enables the periodic redraw counter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_L1,
    ST_CHAR_L1,
    ST_ADDR_L2,
    ST_CHAR_L2
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_LINE1  = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2  = 8'hC0;
  localparam logic [7:0] LCD_BLANK_CHAR = 8'h20;

  localparam int LCD_CELLS          = 32;
  localparam int LCD_FILL_CYCLES    = 32;
  localparam int LCD_XFERS_PER_PASS = 34;

  function automatic logic [4:0] lcd_cell(
    input logic       line2,
    input logic [3:0] col
  );
    return {line2, col};
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: one synchronous write port,
// one asynchronous read port.
module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [LCD_CELLS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams the 2x16 character buffer to an LCD byte controller.
// Define LCD_AUTO_REFRESH_EN for a redraw every REFRESH_CYCLES.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Wr_En,
  input  logic [4:0] Wr_Addr,
  input  logic [7:0] Wr_Data,
  input  logic       Refresh,
  output logic [7:0] Byte_Out,
  output logic       Byte_RS,
  output logic       Byte_Valid,
  input  logic       Byte_Ready,
  output logic       Busy
);

  lcd_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic [7:0] out_q, out_d;
  logic       rs_q, rs_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       fill_q, fill_d;
  logic [4:0] fill_idx_q, fill_idx_d;

  logic       tick;
  logic       req;
  logic       xfer;
  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [4:0] ram_raddr;
  logic [7:0] ram_rdata;

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned CntW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntW'(REFRESH_CYCLES - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tick = 1'b0;
`endif

  assign req       = Refresh | tick;
  assign xfer      = valid_q & Byte_Ready;
  assign ram_raddr = lcd_cell(state_q == ST_CHAR_L2, idx_q);

  lcd_char_ram u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    out_d      = out_q;
    rs_d       = rs_q;
    valid_d    = valid_q;
    fill_d     = fill_q;
    fill_idx_d = fill_idx_q;
    ram_we     = 1'b0;
    ram_waddr  = Wr_Addr;
    ram_wdata  = Wr_Data;

    // The blanking fill owns the write port and masks all requests.
    if (fill_q) begin
      ram_we     = 1'b1;
      ram_waddr  = fill_idx_q;
      ram_wdata  = LCD_BLANK_CHAR;
      fill_idx_d = fill_idx_q + 5'd1;
      if (fill_idx_q == 5'(LCD_FILL_CYCLES - 1)) fill_d = 1'b0;
    end else begin
      ram_we = Wr_En;
      if (state_q != ST_IDLE && (req || Wr_En)) pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fill_q && (req || pending_q)) begin
          state_d   = ST_ADDR_L1;
          idx_d     = 4'd0;
          pending_d = 1'b0;
        end
      end
      ST_ADDR_L1, ST_ADDR_L2: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = (state_q == ST_ADDR_L1) ? ST_CHAR_L1 : ST_CHAR_L2;
        end else if (!valid_q) begin
          out_d   = (state_q == ST_ADDR_L1) ? LCD_CMD_LINE1
                                            : LCD_CMD_LINE2;
          rs_d    = 1'b0;
          valid_d = 1'b1;
        end
      end
      ST_CHAR_L1, ST_CHAR_L2: begin
        if (xfer) begin
          valid_d = 1'b0;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'hF)
            state_d = (state_q == ST_CHAR_L1) ? ST_ADDR_L2 : ST_IDLE;
        end else if (!valid_q) begin
          out_d   = ram_rdata;
          rs_d    = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (Reset) ram_we = 1'b0;
    busy_d = fill_d || (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      pending_q  <= 1'b0;
      out_q      <= 8'h00;
      rs_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      fill_q     <= 1'b1;
      fill_idx_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      rs_q       <= rs_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  assign Byte_Out   = out_q;
  assign Byte_RS    = rs_q;
  assign Byte_Valid = valid_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Randomized bench for lcd_text_sequencer against a
// buffer-level model of the expected 34-byte redraw pass.
module tb_lcd_text_sequencer;

  logic       Clock      = 1'b0;
  logic       Reset      = 1'b1;
  logic       Wr_En      = 1'b0;
  logic [4:0] Wr_Addr    = '0;
  logic [7:0] Wr_Data    = '0;
  logic       Refresh    = 1'b0;
  logic       Byte_Ready = 1'b0;
  logic [7:0] Byte_Out;
  logic       Byte_RS;
  logic       Byte_Valid;
  logic       Busy;

  always #5 Clock = ~Clock;

  lcd_text_sequencer #(.REFRESH_CYCLES(100)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Refresh    (Refresh),
    .Byte_Out   (Byte_Out),
    .Byte_RS    (Byte_RS),
    .Byte_Valid (Byte_Valid),
    .Byte_Ready (Byte_Ready),
    .Busy       (Busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mdl [32];
  logic [8:0] xq [$];
  int         rdy_mode = 0;
  int         cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) begin
    #1;
    case (rdy_mode)
      0:       Byte_Ready = 1'b1;
      1:       Byte_Ready = ($urandom_range(0, 3) == 0);
      2:       Byte_Ready = 1'($urandom_range(0, 1));
      default: Byte_Ready = 1'b0;
    endcase
  end

  // Values seen here are the ones present at the next rising edge.
  logic       stall_p = 1'b0;
  logic       rst_p   = 1'b1;
  logic [8:0] held_p  = '0;

  always @(negedge Clock) begin
    if (stall_p && !rst_p) begin
      check("hold_valid", 32'(Byte_Valid), 32'd1);
      check("hold_data", 32'({Byte_RS, Byte_Out}), 32'(held_p));
    end
    if (Byte_Valid === 1'b1 && Byte_Ready === 1'b1)
      xq.push_back({Byte_RS, Byte_Out});
    stall_p = (Byte_Valid === 1'b1) && !Byte_Ready;
    held_p  = {Byte_RS, Byte_Out};
    rst_p   = Reset;
  end

  function automatic logic [8:0] exp_at(input int i);
    if (i == 0)  return 9'h080;
    if (i < 17)  return {1'b1, mdl[i-1]};
    if (i == 17) return 9'h0C0;
    return {1'b1, mdl[i-2]};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic cmp_pass(input string tag, input int base);
    for (int i = 0; i < 34; i++) begin
      if (base + i < xq.size())
        check(tag, 32'(xq[base+i]), 32'(exp_at(i)));
      else
        check(tag, 32'hDEAD, 32'(exp_at(i)));
    end
  endtask

  task automatic blank_model();
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    Wr_En   = 1'b1;
    Wr_Addr = a;
    Wr_Data = d;
    tick();
    Wr_En   = 1'b0;
    mdl[a]  = d;
  endtask

  task automatic pulse_refresh(input bit chk);
    Refresh = 1'b1;
    tick();
    Refresh = 1'b0;
    if (chk) begin
      check("start_busy", 32'(Busy), 32'd1);
      check("start_novalid", 32'(Byte_Valid), 32'd0);
    end
  endtask

  // Returns once Busy has stayed low for three samples.
  task automatic wait_done(input int budget, output int n);
    int quiet;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      tick();
      n++;
      quiet = (Busy === 1'b1) ? 0 : quiet + 1;
    end
    check("done_timeout", 32'(quiet), 32'd3);
  endtask

  task automatic do_reset(input int hold);
    Reset   = 1'b1;
    Wr_En   = 1'b0;
    Refresh = 1'b0;
    repeat (hold) tick();
    xq.delete();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(Byte_Valid), 32'd0);
    check("rst_out", 32'(Byte_Out), 32'h00);
    check("rst_rs", 32'(Byte_RS), 32'd0);
    Reset = 1'b0;
    blank_model();
    repeat (5) tick();
    check("fill_busy", 32'(Busy), 32'd1);
    Refresh = 1'b1;
    Wr_En   = 1'b1;
    Wr_Addr = 5'd3;
    Wr_Data = 8'h5A;
    tick();
    Refresh = 1'b0;
    Wr_En   = 1'b0;
    repeat (27) tick();
    check("fill_done", 32'(Busy), 32'd0);
    repeat (4) tick();
    check("fill_noreq", 32'(Busy), 32'd0);
    check("fill_noxfer", 32'(xq.size()), 32'd0);
  endtask

  initial begin
    int n;
    blank_model();
    do_reset(2);

`ifdef LCD_AUTO_REFRESH_EN
    begin
      int rises [$];
      logic prev;
      rdy_mode = 0;
      prev = Busy;
      repeat (560) begin
        tick();
        if (Busy && !prev) rises.push_back(cyc);
        prev = Busy;
      end
      check("auto_passes", 32'(rises.size() >= 4), 32'd1);
      for (int i = 1; i < rises.size(); i++)
        check("auto_period", 32'(rises[i] - rises[i-1]), 32'd100);
      check("auto_xfers", 32'(xq.size() >= 4 * 34), 32'd1);
    end
`else
    rdy_mode = 0;
    xq.delete();
    pulse_refresh(1);
    wait_done(2000, n);
    check("a_count", 32'(xq.size()), 32'd34);
    check("a_len_max", 32'((n - 2) <= 68), 32'd1);
    check("a_len_min", 32'((n - 2) >= 34), 32'd1);
    cmp_pass("a_seq", 0);

    rdy_mode = 1;
    xq.delete();
    pulse_refresh(1);
    wait_done(4000, n);
    rdy_mode = 0;
    check("c_count", 32'(xq.size()), 32'd34);
    cmp_pass("c_seq", 0);

    wr(5'd0, 8'h48);
    wr(5'd1, 8'h45);
    wr(5'd2, 8'h4C);
    wr(5'd3, 8'h4C);
    wr(5'd4, 8'h4F);
    wr(5'd16, 8'h57);
    repeat (3) tick();
    xq.delete();
    check("wr_idle_busy", 32'(Busy), 32'd0);
    pulse_refresh(1);
    wait_done(2000, n);
    check("b_count", 32'(xq.size()), 32'd34);
    cmp_pass("b_seq", 0);
    check("b_xfer2", 32'(xq.size() > 1 ? xq[1] : 9'h0), 32'h148);
    check("b_xfer19", 32'(xq.size() > 18 ? xq[18] : 9'h0), 32'h157);

    xq.delete();
    pulse_refresh(1);
    repeat (10) tick();
    pulse_refresh(0);
    repeat (20) tick();
    pulse_refresh(0);
    wait_done(4000, n);
    check("d_count", 32'(xq.size()), 32'd68);
    cmp_pass("d_seq1", 0);
    cmp_pass("d_seq2", 34);

    for (int it = 0; it < 6; it++) begin
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 4))
        wr(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      repeat (2) tick();
      xq.delete();
      check("r_idle", 32'(Busy), 32'd0);
      pulse_refresh(1);
      if ($urandom_range(0, 1) == 1) begin
        wait_done(4000, n);
        check("r_count1", 32'(xq.size()), 32'd34);
        cmp_pass("r_seq", 0);
      end else begin
        repeat (15) tick();
        wr(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        wait_done(8000, n);
        check("r_count2", 32'(xq.size()), 32'd68);
        cmp_pass("r_seq_redraw", 34);
      end
    end

    rdy_mode = 0;
    xq.delete();
    pulse_refresh(1);
    n = 0;
    while (xq.size() < 10 && n < 200) begin
      tick();
      n++;
    end
    check("m_reach10", 32'(xq.size()), 32'd10);
    rdy_mode = 3;
    tick();
    Reset = 1'b1;
    tick();
    check("m_valid0", 32'(Byte_Valid), 32'd0);
    check("m_busy0", 32'(Busy), 32'd0);
    Reset    = 1'b0;
    rdy_mode = 0;
    blank_model();
    repeat (80) tick();
    check("m_noxfer", 32'(xq.size()), 32'd10);
    xq.delete();
    pulse_refresh(1);
    wait_done(2000, n);
    check("m_count", 32'(xq.size()), 32'd34);
    cmp_pass("m_seq", 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_text_sequencer.md
LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000000, giving the auto-refresh period in Clock cycles (used only with LCD_AUTO_REFRESH_EN).
REQ-002 SHALL have port Clock input 1: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port Reset input 1: synchronous, active-high reset.
REQ-004 SHALL have port Wr_En input 1: writes the character buffer this cycle.
REQ-005 SHALL have port Wr_Addr input 5: buffer position; 0-15 is line 1 and 16-31 is line 2.
REQ-006 SHALL have port Wr_Data input 8: ASCII character code.
REQ-007 SHALL have port Refresh input 1: single-cycle request to redraw the whole display.
REQ-008 SHALL have port Byte_Out output 8: command or character byte sent to the downstream LCD nibble controller.
REQ-009 SHALL have port Byte_RS output 1: 0 = command, 1 = character data.
REQ-010 SHALL have port Byte_Valid output 1: Byte_Out and Byte_RS are valid.
REQ-011 SHALL have port Byte_Ready input 1: the downstream controller accepts the byte.
REQ-012 SHALL have port Busy output 1: a redraw pass is in progress.

Function
REQ-013 SHALL hold a 32 x 8 character buffer, written on the cycle Wr_En=1, with a 1-cycle write latency.
REQ-014 SHALL transfer a byte on a rising edge where Byte_Valid=1 and Byte_Ready=1.
REQ-015 SHALL hold Byte_Out and Byte_RS stable, and keep Byte_Valid high, until that transfer occurs.
REQ-016 SHALL implement the states ST_IDLE, ST_ADDR_L1, ST_CHAR_L1, ST_ADDR_L2, ST_CHAR_L2.
REQ-017 SHALL move from ST_IDLE to ST_ADDR_L1 the cycle after Refresh=1 or a pending flag is set; Busy=1 in every state except ST_IDLE.
REQ-018 SHALL, in ST_ADDR_L1, present Byte_Out=0x80 with Byte_RS=0, then go to ST_CHAR_L1 on transfer.
REQ-019 SHALL, in ST_CHAR_L1, present buffer[idx] with Byte_RS=0x1, increment the 4-bit idx on each transfer, and go to ST_ADDR_L2 after idx 15.
REQ-020 SHALL, in ST_ADDR_L2, present Byte_Out=0xC0 with Byte_RS=0, then go to ST_CHAR_L2 on transfer.
REQ-021 SHALL, in ST_CHAR_L2, present buffer[16+idx] and return to ST_IDLE after idx 15; idx wraps to 0.
REQ-022 SHALL produce exactly 34 transfers per pass.
REQ-023 SHALL let Byte_Valid go high no earlier than the cycle after the state is entered, with at most 1 idle cycle between consecutive transfers.
REQ-024 SHALL set a pending flag when Refresh or Wr_En occurs during Busy=1.
REQ-025 SHALL, when the pending flag is set, start exactly one new pass after the current one finishes and clear the flag at that start.
REQ-026 SHALL, when Wr_En and a transfer of the same address occur in the same cycle, send the old byte; the pending flag then guarantees a redraw.
REQ-027 SHALL NOT start a pass from Wr_En while idle; only Refresh, the pending flag or the auto-refresh tick starts a pass.
REQ-028 SHALL take no action on Refresh in the cycle a pass completes beyond setting pending.

Reset
REQ-029 SHALL, on Reset=1 at a rising edge, set state to ST_IDLE, idx=0, pending=0, Byte_Valid=0, Byte_Out=0x00, Byte_RS=0, Busy=0 and the refresh counter to 0.
REQ-030 SHALL fill the whole buffer with 0x20 (space) on reset, taking at most 32 cycles.
REQ-031 SHALL keep Busy=1 and ignore Wr_En and Refresh while that fill runs.
REQ-032 SHALL abandon a pass mid-transfer on Reset, with no further Byte_Valid until a new request.

Configuration
REQ-033 SHALL, with LCD_AUTO_REFRESH_EN defined, run a counter that issues an internal Refresh every REFRESH_CYCLES cycles; that tick is treated identically to the Refresh port, including pending on Busy.
REQ-034 SHALL, without LCD_AUTO_REFRESH_EN, contain no counter, so passes start only from Refresh or pending.

Structure
REQ-035 SHALL place the state encoding, LCD_CMD_LINE1=0x80, LCD_CMD_LINE2=0xC0 and LCD_BLANK_CHAR=0x20 in the shared package lcd_pkg, alongside the controller's timing constants.
REQ-036 SHALL implement the buffer as a single sub-module lcd_char_ram: 32x8, one synchronous write port and one asynchronous read port.

Verification
REQ-037 SHALL cover: Reset, then Refresh with Byte_Ready tied to 1 -> 34 transfers in order: 0x80, 16x 0x20, 0xC0, 16x 0x20, then Busy=0.
REQ-038 SHALL cover: write "HELLO" at 0-4 and 'W' at 16, then Refresh -> transfer bytes 2-6 are 0x48,0x45,0x4C,0x4C,0x4F and transfer byte 19 is 0x57.
REQ-039 SHALL cover: Byte_Ready toggled 1-in-4 cycles -> Byte_Out and Byte_RS never change while Byte_Valid=1 without a transfer, and the sequence is identical to the first scenario.
REQ-040 SHALL cover: Refresh twice during one pass -> exactly two passes (68 transfers) in total.
REQ-041 SHALL cover: Reset asserted after the 10th transfer -> Byte_Valid=0 the next cycle, and no transfers until a new Refresh.
REQ-042 SHALL cover: LCD_AUTO_REFRESH_EN with REFRESH_CYCLES=100 and no Refresh -> a pass starts every 100 cycles.
